// File: rtl/pin_io_sync.sv
// Pad-input conditioning: synchronises raw pad levels into clock_80, applies a per-pin
// glitch filter, flags filtered edges and muxes driven pins back onto the core input bus.
module pin_io_sync #(
    parameter int                  NUM_PINS    = 32,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  FILTER_LEN  = 4,
    parameter logic [NUM_PINS-1:0] INIT        = '0
) (
    input  logic                clock_80,
    input  logic                inp_resn,
    input  logic [NUM_PINS-1:0] pad_in,
    input  logic [NUM_PINS-1:0] pin_out,
    input  logic [NUM_PINS-1:0] pin_dir,
    input  logic [NUM_PINS-1:0] filter_en,
    output logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] edge_rise,
    output logic [NUM_PINS-1:0] edge_fall
);

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("pin_io_sync: SYNC_STAGES must be 2..4");
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filt
            $error("pin_io_sync: FILTER_LEN must be 1..15");
        end
        if (NUM_PINS < 1 || NUM_PINS > 64) begin : g_bad_pins
            $error("pin_io_sync: NUM_PINS must be 1..64");
        end
    endgenerate

    logic [NUM_PINS-1:0] sync_r [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0] filt_r;
    logic [NUM_PINS-1:0] filt_nxt;
    logic [NUM_PINS-1:0] filt_prev_r;
    logic [CW-1:0]       cnt_r   [NUM_PINS];
    logic [CW-1:0]       cnt_nxt [NUM_PINS];

    always_ff @(posedge clock_80 or negedge inp_resn) begin
        if (!inp_resn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= INIT;
            end
        end else begin
            sync_r[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    // A new level is accepted only after it has differed from filt for FILTER_LEN
    // consecutive cycles; any return to the old level or a bypass cycle restarts the count.
    always_comb begin
        filt_nxt = filt_r;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_nxt[i] = '0;
            if (!filter_en[i]) begin
                filt_nxt[i] = sync_q[i];
            end else if (sync_q[i] != filt_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    filt_nxt[i] = sync_q[i];
                end else begin
                    cnt_nxt[i] = cnt_r[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_80 or negedge inp_resn) begin
        if (!inp_resn) begin
            filt_r      <= INIT;
            filt_prev_r <= INIT;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            filt_r      <= filt_nxt;
            filt_prev_r <= filt_r;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_r[i] <= cnt_nxt[i];
            end
        end
    end

    assign edge_rise = filt_r & ~filt_prev_r;
    assign edge_fall = ~filt_r & filt_prev_r;

    // Driven pins loop back combinationally; the filter keeps tracking the pad underneath.
    assign pin_in = (pin_dir & pin_out) | (~pin_dir & filt_r);

endmodule

// File: tb/tb_pin_io_sync.sv
// Randomised and directed bench for pin_io_sync against a sliding-window reference model.
module tb_pin_io_sync;

    localparam int              NP     = 32;
    localparam int              SS     = 2;
    localparam int              FL     = 4;
    localparam logic [NP-1:0]   INIT_V = '0;
    localparam int              HD     = SS + FL;

    logic          clock_80 = 1'b0;
    logic          inp_resn = 1'b1;
    logic [NP-1:0] pad_in    = '0;
    logic [NP-1:0] pin_out   = '0;
    logic [NP-1:0] pin_dir   = '0;
    logic [NP-1:0] filter_en = '1;
    logic [NP-1:0] pin_in;
    logic [NP-1:0] edge_rise;
    logic [NP-1:0] edge_fall;

    pin_io_sync #(
        .NUM_PINS   (NP),
        .SYNC_STAGES(SS),
        .FILTER_LEN (FL),
        .INIT       (INIT_V)
    ) dut (
        .clock_80 (clock_80),
        .inp_resn (inp_resn),
        .pad_in   (pad_in),
        .pin_out  (pin_out),
        .pin_dir  (pin_dir),
        .filter_en(filter_en),
        .pin_in   (pin_in),
        .edge_rise(edge_rise),
        .edge_fall(edge_fall)
    );

    always #5 clock_80 = ~clock_80;

    int n_cmp = 0;
    int n_mis = 0;

    // pad_hist[k] holds the pad level sampled k+1 edges ago
    logic [NP-1:0] pad_hist [HD];
    logic [NP-1:0] m_filt;
    logic [NP-1:0] m_prev;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < HD; k++) pad_hist[k] = INIT_V;
        m_filt = INIT_V;
        m_prev = INIT_V;
    endfunction

    // The synchronised level seen at this edge is the pad sampled SS edges ago; a filtered
    // pin flips only if every one of the last FL synchronised samples disagrees with it.
    function automatic void model_step();
        logic [NP-1:0] nf;
        logic          all_diff;
        nf = m_filt;
        for (int i = 0; i < NP; i++) begin
            if (!filter_en[i]) begin
                nf[i] = pad_hist[SS-1][i];
            end else begin
                all_diff = 1'b1;
                for (int k = 0; k < FL; k++)
                    if (pad_hist[SS-1+k][i] == m_filt[i]) all_diff = 1'b0;
                if (all_diff) nf[i] = ~m_filt[i];
            end
        end
        m_prev = m_filt;
        m_filt = nf;
        for (int k = HD-1; k > 0; k--) pad_hist[k] = pad_hist[k-1];
        pad_hist[0] = pad_in;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_pin_in"}, 64'(pin_in), 64'((pin_dir & pin_out) | (~pin_dir & m_filt)));
        check_eq({tag, "_rise"}, 64'(edge_rise), 64'(m_filt & ~m_prev));
        check_eq({tag, "_fall"}, 64'(edge_fall), 64'(~m_filt & m_prev));
    endtask

    task automatic tick();
        @(posedge clock_80);
        if (inp_resn) model_step();
        @(negedge clock_80);
        check_outputs("cyc");
    endtask

    // Called away from the rising edge; the whole pulse fits before the next one.
    task automatic apply_reset();
        inp_resn = 1'b0;
        model_reset();
        #1 check_outputs("rst");
        #2 inp_resn = 1'b1;
    endtask

    task automatic cycles_until(input int pin, input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (pin_in[pin] !== lvl && n < 30);
    endtask

    initial begin
        int n;
        model_reset();
        #1 apply_reset();

        // reset with quiet pads: no activity for 20 cycles
        repeat (20) begin
            tick();
            check_eq("t1_no_edge", 64'(edge_rise | edge_fall), 64'd0);
        end

        // filtered rise: sync + filter latency, single-cycle pulse
        pad_in[3] = 1'b1;
        cycles_until(3, 1'b1, n);
        check_eq("t2_latency", 64'(n), 64'd6);
        check_eq("t2_rise", 64'(edge_rise[3]), 64'd1);
        tick();
        check_eq("t2_rise_end", 64'(edge_rise[3]), 64'd0);
        pad_in[3] = 1'b0;
        repeat (10) tick();

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        pad_in[5] = 1'b1;
        repeat (3) tick();
        pad_in[5] = 1'b0;
        repeat (10) begin
            tick();
            check_eq("t3_glitch", 64'(pin_in[5]), 64'd0);
        end
        pad_in[5] = 1'b1;
        repeat (4) tick();
        pad_in[5] = 1'b0;
        cycles_until(5, 1'b1, n);
        check_eq("t3_pulse4", 64'(n), 64'd2);
        repeat (12) tick();

        // bypass fall
        filter_en[7] = 1'b0;
        pad_in[7]    = 1'b1;
        repeat (8) tick();
        pad_in[7] = 1'b0;
        cycles_until(7, 1'b0, n);
        check_eq("t4_latency", 64'(n), 64'd3);
        check_eq("t4_fall", 64'(edge_fall[7]), 64'd1);
        tick();
        check_eq("t4_fall_end", 64'(edge_fall[7]), 64'd0);
        filter_en[7] = 1'b1;
        repeat (4) tick();

        // driven pin loops back with no clock delay
        pin_dir[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            pin_out[0] = ~pin_out[0];
            #1 check_eq("t5_zero_lat", 64'(pin_in[0]), 64'(pin_out[0]));
            tick();
        end
        pin_dir[0] = 1'b0;
        tick();

        // reset mid-count discards progress
        pad_in[11] = 1'b1;
        repeat (4) tick();
        apply_reset();
        cycles_until(11, 1'b1, n);
        check_eq("t6_latency", 64'(n), 64'd6);
        repeat (4) tick();

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NP; i++)
                if ($urandom_range(5) == 0) pad_in[i] = ~pad_in[i];
            pin_out = $urandom;
            if ($urandom_range(15) == 0) pin_dir = $urandom;
            if ($urandom_range(63) == 0) filter_en = $urandom;
            if ($urandom_range(249) == 0) apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
